elastic_pipe_reg: RTL

Parametrised, handshake-driven successor to the fixed IF/ID stage register, usable between any two pipeline stages. It carries one DATA_W-bit payload (for IF/ID: {PC, Instr, PCPlus4}) with valid/ready flow control. A one-entry skid buffer lets the upstream ready be registered. Flush inserts a configurable bubble, and saturating counters record stall and flush activity.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/sat_counter.sv | 19 +
 rtl/elastic_pipe_reg.sv | 61 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for pipeline stage registers (IF/ID payload layout and bubble)
package pipe_pkg;
    localparam int IFID_DATA_W = 96;
    localparam int FIELD_W     = 32;
    localparam int PC_LSB      = 64;
    localparam int INSTR_LSB   = 32;
    localparam int PCPLUS4_LSB = 0;
    localparam logic [FIELD_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [IFID_DATA_W-1:0] IFID_BUBBLE = {32'h0, NOP_INSTR, 32'h0};
    typedef struct packed {
        logic [FIELD_W-1:0] pc;
        logic [FIELD_W-1:0] instr;
        logic [FIELD_W-1:0] pcplus4;
    } ifid_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
// ports: clk, rst (async active-low), inc (count enable), clr (zero, beats inc), cnt (value)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready stage register with skid buffer, flush bubble and stall/flush counters
// ports: clk, rst (async active-low); in_valid/in_data/in_ready upstream; out_valid/out_data/out_ready downstream;
//        flush kills held entries; clr_cnt zeroes counters; stall_cnt/flush_cnt saturating activity counters
import pipe_pkg::*;
module elastic_pipe_reg #(
    parameter int                DATA_W = 96,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic accept, drain;
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : BUBBLE;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            main_valid <= accept;
        end else if (!skid_valid) begin
            if (drain && !accept)
                main_valid <= 1'b0;
            else if (!drain && accept)
                skid_valid <= 1'b1;
        end else if (drain) begin
            skid_valid <= 1'b0;
        end
    // Data slots load whenever their contents are dead or being replaced; the valid bits decide meaning.
    always_ff @(posedge clk) begin
        if (skid_valid ? drain : (!main_valid || drain))
            main_data <= skid_valid ? skid_data : in_data;
        if (!skid_valid)
            skid_data <= in_data;
    end
    sat_counter #(.W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .inc(main_valid && !out_ready), .clr(clr_cnt), .cnt(stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush (
        .clk(clk), .rst(rst), .inc(flush), .clr(clr_cnt), .cnt(flush_cnt)
    );
endmodule
